// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the word-to-byte memory arbiter: FSM encoding and beat geometry.
// A 32-bit word is moved as four byte beats, most significant byte first.
package mem_ctrl_pkg;

    localparam int BEATS  = 4;
    localparam int BEAT_W = $clog2(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        ACK   = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant with a last-grant pointer; grant is combinational from req.
// Latency: 0 cycles to grant, pointer moves on the edge where the grant is accepted.
// Backpressure: a loser keeps req high and wins the next tie.
module rr_arbiter_2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic accept,
    output logic gnt_vld,
    output logic gnt_idx
);

    logic last_q;
    logic last_d;

    // On a tie the master that did not win last time goes first.
    assign gnt_vld = req0 | req1;
    assign gnt_idx = (req0 && req1) ? ~last_q : req1;

    always_comb begin
        last_d = last_q;
        if (accept && gnt_vld) begin
            last_d = gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates two 32-bit word masters onto a byte-wide memory, four big-endian beats per word.
// Latency: ack 6 cycles after req is sampled in IDLE (1 cycle for a misaligned address).
// Backpressure: the losing master holds req; requests are only sampled in IDLE.
module data_mem_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [31:0]           m0_addr,
    input  logic [31:0]           m0_wdata,
    output logic [31:0]           m0_rdata,
    output logic                  m0_ack,
    output logic                  m0_err,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [31:0]           m1_addr,
    input  logic [31:0]           m1_wdata,
    output logic [31:0]           m1_rdata,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata
);

    state_t                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic                    gnt_q, gnt_d;
    logic                    we_q, we_d;
    logic [MEM_ADDR_W-1:2]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic                    accept;
    logic                    gnt_vld;
    logic                    gnt_idx;
    logic                    sel_we;
    logic [31:0]             sel_addr;
    logic [31:0]             sel_wdata;
    logic [BEAT_W-1:0]       cap_idx;
    logic                    ack_any;

    rr_arbiter_2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (m0_req),
        .req1    (m1_req),
        .accept  (accept),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    assign sel_we    = gnt_idx ? m1_we    : m0_we;
    assign sel_addr  = gnt_idx ? m1_addr  : m0_addr;
    assign sel_wdata = gnt_idx ? m1_wdata : m0_wdata;

    // Address bits above the memory window are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^sel_addr[31:MEM_ADDR_W];

    // The byte on mem_rdata belongs to the previous beat; in DRAIN beat_q has wrapped to 0.
    assign cap_idx = beat_q - BEAT_W'(1);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    accept  = 1'b1;
                    gnt_d   = gnt_idx;
                    we_d    = sel_we;
                    addr_d  = sel_addr[MEM_ADDR_W-1:2];
                    wdata_d = sel_wdata;
                    rdata_d = 32'd0;
                    beat_d  = '0;
                    err_d   = (sel_addr[1:0] != 2'b00);
                    state_d = (sel_addr[1:0] != 2'b00) ? ACK : XFER;
                end
            end
            XFER: begin
                beat_d = beat_q + BEAT_W'(1);
                if (!we_q && beat_q != '0) begin
                    rdata_d = rdata_q | ({24'd0, mem_rdata} << {~cap_idx, 3'b000});
                end
                if (beat_q == LAST_BEAT) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!we_q) begin
                    rdata_d = rdata_q | ({24'd0, mem_rdata} << {~cap_idx, 3'b000});
                end
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_en    = (state_q == XFER);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = {addr_q, beat_q};
    assign mem_wdata = wdata_q[{~beat_q, 3'b000} +: 8];

    assign ack_any  = (state_q == ACK);
    assign m0_ack   = ack_any && !gnt_q;
    assign m1_ack   = ack_any &&  gnt_q;
    assign m0_err   = m0_ack && err_q;
    assign m1_err   = m1_ack && err_q;
    assign m0_rdata = m0_ack ? rdata_q : 32'd0;
    assign m1_rdata = m1_ack ? rdata_q : 32'd0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a byte memory model and an ack scoreboard.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'd0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.MEM_ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [7:0] mem [0:1023];
    initial for (int i = 0; i < 1024; i++) mem[i] = 8'd0;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          m;
        logic [31:0] rdata;
        logic        err;
        int          at;
    } exp_t;

    exp_t       exp_q[$];
    int         en_cyc_q[$];
    logic [9:0] en_addr_q[$];
    exp_t       mon_e;
    int         mon_m;

    // Monitor: logs memory strobes and scores every ack against the expectation queue.
    always @(negedge clk) begin
        if (mem_en) begin
            en_cyc_q.push_back(cyc);
            en_addr_q.push_back(mem_addr);
        end
        if (m0_ack || m1_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack: got m0_ack=%b m1_ack=%b expected none (cyc=%0d)",
                         m0_ack, m1_ack, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                mon_m = m1_ack ? 1 : 0;
                chk("ack_master", mon_m, mon_e.m);
                chk("ack_cycle", cyc, mon_e.at);
                chk("ack_rdata", mon_m ? m1_rdata : m0_rdata, mon_e.rdata);
                chk("ack_err", mon_m ? m1_err : m0_err, mon_e.err);
                chk("other_master_quiet",
                    mon_m ? (m0_rdata | {30'd0, m0_ack, m0_err}) : (m1_rdata | {30'd0, m1_ack, m1_err}),
                    32'd0);
            end
        end
    end

    task automatic drive(input int m, input logic r, input logic we, input logic [31:0] a,
                         input logic [31:0] d);
        if (m == 0) begin
            m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d;
        end
    endtask

    task automatic drop(input int m);
        if (m == 0) m0_req = 1'b0;
        else        m1_req = 1'b0;
    endtask

    task automatic push_exp(input int m, input logic [31:0] rd, input logic err, input int at);
        exp_t e;
        e.m = m; e.rdata = rd; e.err = err; e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input int m);
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = (m == 0) ? m0_ack : m1_ack;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout: master %0d got no ack within 40 cycles, expected one", m);
        end
    endtask

    task automatic single(input int m, input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rd, input logic err, input int lat, output int n0);
        @(posedge clk); #1;
        en_cyc_q.delete();
        en_addr_q.delete();
        drive(m, 1'b1, we, a, d);
        n0 = cyc;
        push_exp(m, rd, err, n0 + lat);
        wait_ack(m);
        drop(m);
    endtask

    task automatic check_beats(input string name, input int n0, input logic [9:0] base,
                               input int count);
        chk({name, "_strobe_count"}, en_cyc_q.size(), count);
        for (int i = 0; i < en_cyc_q.size() && i < count; i++) begin
            chk({name, "_strobe_cycle"}, en_cyc_q[i], n0 + 1 + i);
            chk({name, "_strobe_addr"}, {22'd0, en_addr_q[i]}, {22'd0, base + 10'(i)});
        end
    endtask

    function automatic logic [31:0] mem_word(input int a);
        return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_strobes", {30'd0, mem_en, mem_we}, 32'd0);
        chk("reset_acks", {28'd0, m0_ack, m0_err, m1_ack, m1_err}, 32'd0);
        chk("reset_mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("reset_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        chk("reset_rdata", m0_rdata | m1_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Tie straight after reset: m0, m1, m0 with both requests held.
        @(posedge clk); #1;
        en_cyc_q.delete();
        en_addr_q.delete();
        drive(0, 1'b1, 1'b1, 32'h30, 32'hA0A1A2A3);
        drive(1, 1'b1, 1'b1, 32'h34, 32'hB0B1B2B3);
        n0 = cyc;
        push_exp(0, 32'd0, 1'b0, n0 + 6);
        push_exp(1, 32'd0, 1'b0, n0 + 13);
        push_exp(0, 32'd0, 1'b0, n0 + 20);
        chk("tie_first_grant_addr", en_cyc_q.size(), 0);
        wait_ack(1);
        drop(1);
        wait_ack(0);
        drop(0);
        chk("tie_m0_word", mem_word(32'h30), 32'hA0A1A2A3);
        chk("tie_m1_word", mem_word(32'h34), 32'hB0B1B2B3);

        // m0 write, then m1 reads it back.
        single(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 6, n0);
        check_beats("wr10", n0, 10'h010, 4);
        chk("wr10_word", mem_word(32'h10), 32'hDEADBEEF);

        single(1, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 6, n0);
        check_beats("rd10", n0, 10'h010, 4);

        // Misaligned read: immediate error ack, no memory access.
        single(0, 1'b0, 32'h13, 32'd0, 32'd0, 1'b1, 1, n0);
        check_beats("misalign", n0, 10'h000, 0);

        // Upper address bits beyond the memory window are ignored.
        single(0, 1'b0, 32'h410, 32'd0, 32'hDEADBEEF, 1'b0, 6, n0);
        check_beats("rd410", n0, 10'h010, 4);

        single(1, 1'b1, 32'h08, 32'h01020304, 32'd0, 1'b0, 6, n0);
        single(0, 1'b0, 32'h08, 32'd0, 32'h01020304, 1'b0, 6, n0);
        check_beats("rd08", n0, 10'h008, 4);

        // Reset in the middle of a write: two bytes land, no ack.
        @(posedge clk); #1;
        en_cyc_q.delete();
        en_addr_q.delete();
        drive(1, 1'b1, 1'b1, 32'h20, 32'h11223344);
        n0 = cyc;
        while (cyc < n0 + 3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_mem_en", {31'd0, mem_en}, 32'd0);
        chk("abort_mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("abort_ack", {30'd0, m0_ack, m1_ack}, 32'd0);
        drop(1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_partial_word", mem_word(32'h20), 32'h11220000);
        check_beats("abort", n0, 10'h020, 2);

        single(0, 1'b0, 32'h20, 32'd0, 32'h11220000, 1'b0, 6, n0);
        check_beats("after_abort", n0, 10'h020, 4);

        repeat (4) @(negedge clk);
        chk("pending_expectations", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter MEM_ADDR_W, default 10, SHALL set the byte-address width of the memory port (1024 bytes).
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Ports m0_req / m1_req  input  1 each  SHALL be the request from master 0 / 1.
REQ-005 Ports m0_we / m1_we  input  1 each  SHALL select write (1) or read (0).
REQ-006 Ports m0_addr / m1_addr  input  32 each  SHALL be the byte address of a 32-bit word.
REQ-007 Ports m0_wdata / m1_wdata  input  32 each  SHALL be the write word.
REQ-008 Ports m0_rdata / m1_rdata  output  32 each  SHALL be the read word, valid only while the matching ack is high.
REQ-009 Ports m0_ack / m1_ack  output  1 each  SHALL be one-cycle completion pulses.
REQ-010 Ports m0_err / m1_err  output  1 each  SHALL flag a misaligned request; valid only with ack.
REQ-011 Port mem_en  output  1  SHALL be the byte-memory access strobe.
REQ-012 Port mem_we  output  1  SHALL be the byte write enable; qualified by mem_en.
REQ-013 Port mem_addr  output  MEM_ADDR_W  SHALL be the byte address.
REQ-014 Port mem_wdata  output  8  SHALL be the byte write data.
REQ-015 Port mem_rdata  input  8  SHALL carry the byte read, valid the cycle after a read strobe.

Function
REQ-016 FSM states SHALL be IDLE, XFER, DRAIN and ACK.
REQ-017 In IDLE, on any req, the arbiter SHALL grant one master, latch its we/addr/wdata, and go to XFER with beat=0; with no req it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: on simultaneous requests, the master not granted last wins; the last-grant pointer resets to m1, so m0 wins the first tie.
REQ-019 In XFER, the arbiter SHALL assert mem_en for 4 consecutive cycles, beat 0..3, with mem_addr = {addr[MEM_ADDR_W-1:2], beat[1:0]}; upper address bits are ignored and no carry or wrap is possible.
REQ-020 Byte order SHALL be big-endian: beat k writes wdata[31-8k:24-8k], and the read byte from beat k fills rdata[31-8k:24-8k].
REQ-021 Each read byte SHALL be captured the cycle after its strobe; DRAIN (mem_en=0) captures the beat-3 byte; writes also pass through DRAIN.
REQ-022 In ACK, the arbiter SHALL pulse the granted master's ack for exactly 1 cycle with rdata (reads) or 0 (writes), then return to IDLE.
REQ-023 Latency SHALL be fixed: req sampled in IDLE at cycle 0, mem_en in cycles 1-4, DRAIN in cycle 5, ack in cycle 6; next grant no earlier than cycle 7.
REQ-024 If addr[1:0]≠0, the arbiter SHALL go IDLE→ACK directly with err=1, rdata=0 and no mem_en; ack then occurs in cycle 1.
REQ-025 Requests SHALL NOT be sampled outside IDLE; a master's signals must stay stable from req until ack; the non-granted master waits with req held.
REQ-026 A req still high during its own ACK cycle SHALL be treated as a new request in the following IDLE cycle.
REQ-027 The non-granted master's ack, err and rdata SHALL stay 0.

Reset
REQ-028 On rst_n low, the block SHALL immediately, without waiting for a clock, enter IDLE and drive mem_en, mem_we, all acks and errs to 0; it SHALL set mem_addr, mem_wdata, rdata and beat to 0, and the last-grant pointer to m1.
REQ-029 Reset during XFER SHALL abort the transfer with no ack; bytes already written remain in memory, and no rollback is attempted.
REQ-030 After rst_n deasserts, the first grant SHALL occur no earlier than the first rising edge with rst_n high.

Structure
REQ-031 Shared package mem_ctrl_pkg SHALL hold the state encoding, BEATS=4 and the beat-index width.
REQ-032 Sub-module rr_arbiter_2 SHALL hold the two-way round-robin grant and the last-grant pointer; the FSM and datapath SHALL stay in data_mem_arbiter.

Verification
REQ-033 m0 write, addr=0x10, wdata=0xDEADBEEF -> bytes DE,AD,BE,EF at 0x10-0x13 in cycles 1-4; m0_ack in cycle 6, err=0.
REQ-034 m1 read, addr=0x10 after REQ-033 -> m1_rdata=0xDEADBEEF with m1_ack in cycle 6.
REQ-035 m0 and m1 request in the same cycle straight after reset, then both hold req -> grant order m0, m1, m0; ack pulses in cycles 6, 13, 20.
REQ-036 m0 read, addr=0x13 -> m0_ack with m0_err=1 and rdata=0 in cycle 1; mem_en never asserted.
REQ-037 m1 write, addr=0x20, wdata=0x11223344, with rst_n pulsed low in cycle 3 -> mem_en drops during reset; no ack; 0x20-0x21 hold 11,22; next request completes normally.
REQ-038 m0 read, addr=0x410 with MEM_ADDR_W=10 -> mem_addr 0x010-0x013; data matches the REQ-033 word.
